// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types, sizes and helpers for the 4x4 keypad scan controller.
//   scan_state_t : controller state (SCAN, DEBOUNCE, HELD)
//   COLS / ROWS  : matrix dimensions
//   COL_RESET    : column strobe driven after reset
//   keymap()     : one-hot column + one-hot row -> 4-bit key code
//   is_onehot()  : true when exactly one row bit is set
//   rotate_col() : next column strobe in the scan sequence
package keypad_pkg;

    localparam int COLS = 4;
    localparam int ROWS = 4;

    localparam logic [COLS-1:0] COL_RESET = 4'b0001;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    // Keypad legend. Anything that is not a single column and single row
    // decodes to F so an impossible combination never aliases a digit.
    function automatic logic [3:0] keymap(input logic [COLS-1:0] col_onehot,
                                          input logic [ROWS-1:0] row_onehot);
        logic [3:0] code;
        case ({col_onehot, row_onehot})
            8'b0001_0001: code = 4'h1;
            8'b0001_0010: code = 4'h2;
            8'b0001_0100: code = 4'h3;
            8'b0001_1000: code = 4'hA;
            8'b0010_0001: code = 4'h4;
            8'b0010_0010: code = 4'h5;
            8'b0010_0100: code = 4'h6;
            8'b0010_1000: code = 4'hB;
            8'b0100_0001: code = 4'h7;
            8'b0100_0010: code = 4'h8;
            8'b0100_0100: code = 4'h9;
            8'b0100_1000: code = 4'hC;
            8'b1000_0001: code = 4'hE;
            8'b1000_0010: code = 4'h0;
            8'b1000_0100: code = 4'hF;
            8'b1000_1000: code = 4'hD;
            default:      code = 4'hF;
        endcase
        return code;
    endfunction

    // Zero and multi-hot samples (ghosting / two keys) both return 0.
    function automatic logic is_onehot(input logic [ROWS-1:0] v);
        return (v != {ROWS{1'b0}}) && ((v & (v - ROWS'(1))) == {ROWS{1'b0}});
    endfunction

    function automatic logic [COLS-1:0] rotate_col(input logic [COLS-1:0] c);
        return {c[COLS-2:0], c[COLS-1]};
    endfunction

endpackage

// File: rtl/keypad_scan_controller_if.sv
// keypad_scan_controller_if
// Bundles the keypad pin side and the key-event side of the controller.
//   row_in    : raw rows from the keypad (asynchronous, active-high)
//   col_out   : one-hot column drive
//   key_code  : last accepted key code
//   key_valid : one-cycle strobe when key_code updates
//   key_held  : accepted key not yet released
// slave  : the controller
// master : the environment (keypad pins + operand-entry consumer)
interface keypad_scan_controller_if;
    import keypad_pkg::*;

    logic [ROWS-1:0] row_in;
    logic [COLS-1:0] col_out;
    logic [3:0]      key_code;
    logic            key_valid;
    logic            key_held;

    modport slave (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_held
    );

    modport master (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen
// Column dwell counter. Counts 0..SCAN_DIV-1 continuously and raises
// tick_o for exactly the cycle in which the count equals SCAN_DIV-1.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick_o     : registered one-cycle tick, once per SCAN_DIV cycles
module keypad_tick_gen #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int              CW   = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]   LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;

    // Next count and next tick; the tick is precomputed from the next
    // count so it lines up with the cycle in which cnt_q == LAST.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (cnt_q == LAST) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        tick_d = (cnt_d == LAST);
    end

    // Counter and tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {CW{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/keypad_scan_controller.sv
// keypad_scan_controller
// Scans a 4x4 matrix keypad with a one-hot column strobe, synchronizes the
// rows, debounces press and release on scan ticks and reports each accepted
// key once with a one-cycle valid strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   kp         : keypad_scan_controller_if.slave (row_in in; col_out,
//                key_code, key_valid, key_held out)
// Parameters: SCAN_DIV (cycles per column, >= 2),
//             DEBOUNCE_CNT (matching tick samples to accept, >= 1).
module keypad_scan_controller
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    keypad_scan_controller_if.slave  kp
);

    localparam int            DW       = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CNT);
    // With a single-sample debounce the detection tick is also the accept tick.
    localparam bit            ACCEPT_ON_DETECT = (DEBOUNCE_CNT == 1);

    logic            tick_s;
    logic [ROWS-1:0] sync1_q;
    logic [ROWS-1:0] rows_s_q;

    scan_state_t     state_q,    state_d;
    logic [COLS-1:0] col_q,      col_d;
    logic [ROWS-1:0] cand_row_q, cand_row_d;
    logic [COLS-1:0] cand_col_q, cand_col_d;
    logic [DW-1:0]   deb_cnt_q,  deb_cnt_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            key_held_q,  key_held_d;
    logic [DW-1:0]   deb_inc_s;

    keypad_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick_s)
    );

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= {ROWS{1'b0}};
            rows_s_q <= {ROWS{1'b0}};
        end else begin
            sync1_q  <= kp.row_in;
            rows_s_q <= sync1_q;
        end
    end

    assign deb_inc_s = deb_cnt_q + DW'(1);

    // Scan / debounce / held next-state and output logic. All decisions are
    // taken only on a tick; between ticks everything holds.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        cand_row_d  = cand_row_q;
        cand_col_d  = cand_col_q;
        deb_cnt_d   = deb_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            SCAN: begin
                if (tick_s) begin
                    if (is_onehot(rows_s_q)) begin
                        // Freeze the column on the candidate key.
                        cand_row_d = rows_s_q;
                        cand_col_d = col_q;
                        if (ACCEPT_ON_DETECT) begin
                            key_code_d  = keymap(col_q, rows_s_q);
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            deb_cnt_d   = {DW{1'b0}};
                            state_d     = HELD;
                        end else begin
                            deb_cnt_d   = DW'(1);
                            state_d     = DEBOUNCE;
                        end
                    end else begin
                        col_d = rotate_col(col_q);
                    end
                end else begin
                    col_d = col_q;
                end
            end

            DEBOUNCE: begin
                if (tick_s) begin
                    if (rows_s_q == cand_row_q) begin
                        if (deb_inc_s == DEB_MAX) begin
                            key_code_d  = keymap(cand_col_q, cand_row_q);
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            deb_cnt_d   = {DW{1'b0}};
                            state_d     = HELD;
                        end else begin
                            deb_cnt_d   = deb_inc_s;
                        end
                    end else begin
                        // Bounce or a different key: abandon and move on.
                        deb_cnt_d = {DW{1'b0}};
                        col_d     = rotate_col(col_q);
                        state_d   = SCAN;
                    end
                end else begin
                    deb_cnt_d = deb_cnt_q;
                end
            end

            HELD: begin
                if (tick_s) begin
                    if (rows_s_q == {ROWS{1'b0}}) begin
                        if (deb_inc_s == DEB_MAX) begin
                            key_held_d = 1'b0;
                            deb_cnt_d  = {DW{1'b0}};
                            col_d      = rotate_col(col_q);
                            state_d    = SCAN;
                        end else begin
                            deb_cnt_d  = deb_inc_s;
                        end
                    end else begin
                        // Any activity restarts the release count; it never re-fires.
                        deb_cnt_d = {DW{1'b0}};
                    end
                end else begin
                    deb_cnt_d = deb_cnt_q;
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean scan.
                state_d    = SCAN;
                col_d      = COL_RESET;
                deb_cnt_d  = {DW{1'b0}};
                key_held_d = 1'b0;
            end
        endcase
    end

    // Controller state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            col_q       <= COL_RESET;
            cand_row_q  <= {ROWS{1'b0}};
            cand_col_q  <= {COLS{1'b0}};
            deb_cnt_q   <= {DW{1'b0}};
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            cand_row_q  <= cand_row_d;
            cand_col_q  <= cand_col_d;
            deb_cnt_q   <= deb_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp.col_out   = col_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Testbench for keypad_scan_controller: a simulated key matrix drives the
// rows from the DUT's column strobe; a tick-level reference model predicts
// column, held flag and accepted keys; a scoreboard queue holds expected
// key codes which a monitor pops whenever key_valid is seen.
module tb_keypad_scan_controller;

    localparam int SD = 4;
    localparam int DC = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_scan_controller_if kp();

    keypad_scan_controller #(
        .SCAN_DIV     (SD),
        .DEBOUNCE_CNT (DC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- keypad matrix ----------------
    logic [15:0] pressed = 16'h0;   // bit c*4+r = key at column c, row r
    bit          bounce_on = 1'b0;
    bit          bphase = 1'b0;
    int          bcnt = 0;

    initial begin
        logic [3:0] rows;
        kp.row_in = 4'h0;
        forever begin
            @(negedge clk);
            if (bounce_on) begin
                bcnt++;
                if (bcnt % 3 == 0) bphase = ~bphase;
            end else begin
                bcnt = 0;
                bphase = 1'b0;
            end
            rows = 4'h0;
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (kp.col_out[c] && pressed[c*4+r] && !bphase) rows[r] = 1'b1;
            kp.row_in = rows;
        end
    end

    // ---------------- reference model ----------------
    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

    int         e = 0, ci = 0, mode = 0, n = 0;   // mode 0 scan, 1 debounce, 2 held
    logic [3:0] h1 = 4'h0, h2 = 4'h0, rs, cand = 4'h0;
    logic [3:0] m_code = 4'h0;
    bit         m_valid = 1'b0, m_held = 1'b0;
    logic [3:0] exp_q[$];

    function automatic int bitpos(input logic [3:0] v);
        int p = 0;
        for (int i = 0; i < 4; i++) if (v[i]) p = i;
        return p;
    endfunction

    task automatic model_accept();
        m_code = kmap[ci*4 + bitpos(cand)];
        exp_q.push_back(m_code);
        m_valid = 1'b1;
        m_held = 1'b1;
        mode = 2;
        n = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                e = 0; ci = 0; mode = 0; n = 0;
                h1 = 4'h0; h2 = 4'h0; cand = 4'h0;
                m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
                exp_q.delete();
            end else begin
                rs = h2; h2 = h1; h1 = kp.row_in;
                m_valid = 1'b0;
                if (e % SD == SD - 1) begin
                    case (mode)
                        0: begin
                            if ($countones(rs) == 1) begin
                                cand = rs; n = 1; mode = 1;
                                if (n >= DC) model_accept();
                            end else begin
                                ci = (ci + 1) % 4;
                            end
                        end
                        1: begin
                            if (rs == cand) begin
                                n++;
                                if (n >= DC) model_accept();
                            end else begin
                                mode = 0; n = 0; ci = (ci + 1) % 4;
                            end
                        end
                        default: begin
                            if (rs == 4'h0) n++; else n = 0;
                            if (n >= DC) begin
                                mode = 0; n = 0; ci = (ci + 1) % 4; m_held = 1'b0;
                            end
                        end
                    endcase
                end
                e++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [3:0] exp_code;
        forever begin
            @(negedge clk);
            check("col_out",   {28'h0, kp.col_out}, 32'(4'b0001 << ci));
            check("key_valid", {31'h0, kp.key_valid}, {31'h0, m_valid});
            check("key_held",  {31'h0, kp.key_held}, {31'h0, m_held});
            check("key_code",  {28'h0, kp.key_code}, {28'h0, m_code});
            if (kp.key_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: key_valid with code %0h, expected no key", kp.key_code);
                end else begin
                    exp_code = exp_q.pop_front();
                    check("sb_code", {28'h0, kp.key_code}, {28'h0, exp_code});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int k, dur, waited;
        repeat (3) @(negedge clk);
        check("rst_col",   {28'h0, kp.col_out}, 32'h1);
        check("rst_code",  {28'h0, kp.key_code}, 32'h0);
        check("rst_valid", {31'h0, kp.key_valid}, 32'h0);
        check("rst_held",  {31'h0, kp.key_held}, 32'h0);
        rst_n = 1'b1;

        // Idle scanning.
        repeat (24) @(negedge clk);
        check("idle_code", {28'h0, kp.key_code}, 32'h0);

        // Key 5 (col 1, row 1) held, then released.
        pressed[1*4+1] = 1'b1;
        repeat (40) @(negedge clk);
        check("k5_held", {31'h0, kp.key_held}, 32'h1);
        check("k5_code", {28'h0, kp.key_code}, 32'h5);
        check("k5_col",  {28'h0, kp.col_out}, 32'h2);
        pressed = 16'h0;
        repeat (30) @(negedge clk);
        check("k5_release", {31'h0, kp.key_held}, 32'h0);

        // Ghost pattern 0101 on column 0 must never be accepted.
        pressed[0] = 1'b1;
        pressed[2] = 1'b1;
        repeat (50) @(negedge clk);
        check("ghost_code", {28'h0, kp.key_code}, 32'h5);
        check("ghost_held", {31'h0, kp.key_held}, 32'h0);
        pressed = 16'h0;
        repeat (8) @(negedge clk);

        // Key 0 (col 3, row 1) with contact bounce while column 3 is driven.
        waited = 0;
        while (kp.col_out !== 4'b1000 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("wait_col3", {31'h0, (waited < 40)}, 32'h1);
        pressed[3*4+1] = 1'b1;
        bounce_on = 1'b1;
        repeat (8) @(negedge clk);
        bounce_on = 1'b0;
        repeat (60) @(negedge clk);
        check("k0_code", {28'h0, kp.key_code}, 32'h0);
        check("k0_held", {31'h0, kp.key_held}, 32'h1);
        pressed = 16'h0;
        repeat (40) @(negedge clk);

        // Key 9 held, then asynchronous reset while HELD.
        pressed[2*4+2] = 1'b1;
        repeat (50) @(negedge clk);
        check("k9_code", {28'h0, kp.key_code}, 32'h9);
        check("k9_held", {31'h0, kp.key_held}, 32'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_col",   {28'h0, kp.col_out}, 32'h1);
        check("arst_code",  {28'h0, kp.key_code}, 32'h0);
        check("arst_valid", {31'h0, kp.key_valid}, 32'h0);
        check("arst_held",  {31'h0, kp.key_held}, 32'h0);
        repeat (2) @(negedge clk);
        pressed = 16'h0;
        rst_n = 1'b1;
        #1;
        check("arst_restart_col", {28'h0, kp.col_out}, 32'h1);
        repeat (20) @(negedge clk);

        // Randomized key activity.
        for (int it = 0; it < 30; it++) begin
            pressed = 16'h0;
            k = $urandom_range(0, 3);
            if (k >= 1) pressed[$urandom_range(0, 15)] = 1'b1;
            if (k == 2) pressed[$urandom_range(0, 15)] = 1'b1;
            bounce_on = (k == 3);
            dur = $urandom_range(10, 70);
            repeat (dur) @(negedge clk);
            bounce_on = 1'b0;
            repeat ($urandom_range(0, 20)) @(negedge clk);
            pressed = 16'h0;
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end

        pressed = 16'h0;
        repeat (40) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_controller.md
Name: keypad_scan_controller

Overview:
Sequences the 4x4 matrix keypad. It drives a one-hot column strobe and samples the four row lines through a synchronizer. It debounces press and release, then emits the decoded key code together with a single-cycle valid strobe. It sits between the keypad pins and the adder's operand-entry logic, and replaces free-running column shifting plus edge-clocked decoding with a fully synchronous, single-clock controller.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven (dwell). Legal range is 2 or more. A scan tick fires on the last cycle of each dwell.
- DEBOUNCE_CNT, 4: consecutive identical tick samples needed to accept a press, or consecutive all-zero tick samples needed to accept a release. Legal range is 1 or more.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- row_in, input, 4: raw keypad rows, active-high, asynchronous to clk.
- col_out, output, 4: one-hot column drive, active-high.
- key_code, output, 4: code of the last accepted key. Holds its value until the next accepted key.
- key_valid, output, 1: one-cycle pulse when key_code has just been updated.
- key_held, output, 1: high while an accepted key has not yet been debounced as released.

Behaviour:
- Reset values:
  - col_out = 4'b0001
  - key_code = 4'h0
  - key_valid = 0
  - key_held = 0
  - state = SCAN
  - dwell counter, debounce counter and synchronizer flops = 0
- Synchronizer: row_in passes through a 2-flop synchronizer, giving rows_s. Every decision uses rows_s sampled on a tick.
- Tick: the dwell counter counts 0 to SCAN_DIV-1 and wraps. tick=1 when the count equals SCAN_DIV-1. The counter runs in every state.
- Column rotation occurs only in SCAN, on tick: 0001 -> 0010 -> 0100 -> 1000 -> 0001.
- Key map, written as col bit, then row bit, then code:
  - Col 0: row0 = 1, row1 = 2, row2 = 3, row3 = A.
  - Col 1: row0 = 4, row1 = 5, row2 = 6, row3 = B.
  - Col 2: row0 = 7, row1 = 8, row2 = 9, row3 = C.
  - Col 3: row0 = E, row1 = 0, row2 = F, row3 = D.
- State SCAN, on each tick:
  - Exactly one bit of rows_s set: latch cand_row = rows_s and cand_col = col_out, set deb_cnt = 1, go to DEBOUNCE. col_out stays frozen.
  - rows_s zero or multi-hot: rotate the column and remain in SCAN.
- State DEBOUNCE (col_out frozen), on each tick:
  - rows_s == cand_row: deb_cnt += 1.
  - rows_s differs: go to SCAN, rotate the column, clear deb_cnt.
  - Acceptance check uses the post-increment value. If deb_cnt reaches DEBOUNCE_CNT:
    - Load key_code from the map.
    - Pulse key_valid for exactly 1 cycle, the cycle after that tick.
    - Go to HELD with deb_cnt = 0.
  - If DEBOUNCE_CNT = 1, acceptance happens directly from the SCAN detection tick.
- State HELD (col_out frozen, key_held=1), on each tick:
  - rows_s == 0: deb_cnt += 1.
  - Otherwise: deb_cnt = 0. A glitch or a second key does not re-fire.
  - When deb_cnt reaches DEBOUNCE_CNT: key_held=0, go to SCAN, rotate the column, clear deb_cnt.
- key_held rises in the same cycle as key_valid.
- No auto-repeat. A held key produces exactly one key_valid.
- Ghosting and multiple keys:
  - A multi-hot row sample is never accepted.
  - A second key in another column is invisible while the column is frozen.
- Latency: from a stable press on the driven column, key_valid follows 2 sync cycles plus up to DEBOUNCE_CNT ticks plus 1 cycle.
- Asynchronous reset mid-operation forces the reset values immediately, including dropping key_held and any pending key_valid.

Decomposition:
- Package keypad_pkg holds:
  - enum scan_state_t = {SCAN, DEBOUNCE, HELD}
  - localparams COLS=4 and ROWS=4
  - function keymap(col_onehot, row_onehot) returning a 4-bit code, default 4'hF.
- One sub-module, keypad_tick_gen: the SCAN_DIV dwell counter plus the tick output.
- The 2-flop synchronizer and FSM stay inline.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_CNT=3.
1. Reset, then idle with rows=0 -> col_out cycles 0001, 0010, 0100, 1000 every 4 clocks; key_valid never asserts; key_code = 0.
2. Hold row_in=0010 only while col_out=0010 is driven, for 5 or more ticks -> col_out freezes at 0010; exactly one key_valid pulse; key_code=4'h5; key_held=1.
3. From HELD, release rows for 3 ticks -> key_held falls; scanning resumes; no further key_valid.
4. Press row1 on col 3 with bounce (toggling row_in every 3 clocks for 2 ticks, then stable) -> return to SCAN on each mismatch, then a single valid with key_code=4'h0.
5. row_in=0101 on col 0 -> no acceptance; scanning continues; key_code unchanged.
6. Assert rst_n=0 during HELD -> outputs return to reset values immediately; after release, scanning restarts at col_out=0001.
